// File: rtl/uart_io_16.sv
// Memory-mapped 8N1 UART on the 16-bit system bus, with 16-entry TX and RX FIFOs.
// Define UART_IRQ_EN to add the IE register at offset 0x04 and a registered irq_o.
module uart_io_16 #(
  parameter logic [15:0] BASE_ADDR = 16'h4000,
  parameter int unsigned CLK_HZ    = 50000000,
  parameter int unsigned BAUD      = 115200,
  parameter int unsigned FIFO_AW   = 4
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic [15:0] addr_i,
  input  logic [15:0] din_i,
  output logic [15:0] dout_o,
  input  logic        we_i,
  input  logic        rx_i,
  output logic        tx_o,
  output logic        irq_o
);
  localparam int unsigned DivRst = CLK_HZ / BAUD;
  localparam int unsigned Depth  = 1 << FIFO_AW;
  localparam logic [FIFO_AW:0] Full = Depth[FIFO_AW:0];

  typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

  logic sel, wr_data, wr_stat, wr_pop, wr_div;
  logic [7:0] off;
  assign sel     = addr_i[15:8] == BASE_ADDR[15:8];
  assign off     = addr_i[7:0];
  assign wr_data = we_i && sel && (off == 8'h00);
  assign wr_stat = we_i && sel && (off == 8'h01);
  assign wr_pop  = we_i && sel && (off == 8'h02);
  assign wr_div  = we_i && sel && (off == 8'h03);

  logic [15:0] div_q;
  always_ff @(posedge clk_i) begin
    if (reset_i)     div_q <= DivRst[15:0];
    else if (wr_div) div_q <= (din_i < 16'd4) ? 16'd4 : din_i;
  end

  // TX FIFO
  logic [7:0]         tx_mem [Depth];
  logic [FIFO_AW-1:0] tx_head_q, tx_tail_q;
  logic [FIFO_AW:0]   tx_cnt_q;
  logic               tx_empty, tx_full, tx_pop, tx_do_push;
  state_e             tx_state_q;
  assign tx_empty   = tx_cnt_q == '0;
  assign tx_full    = tx_cnt_q == Full;
  assign tx_pop     = (tx_state_q == StIdle) && !tx_empty;
  assign tx_do_push = wr_data && (!tx_full || tx_pop);

  always_ff @(posedge clk_i) begin
    if (tx_do_push) tx_mem[tx_tail_q] <= din_i[7:0];
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      tx_head_q <= '0;
      tx_tail_q <= '0;
      tx_cnt_q  <= '0;
    end else begin
      if (tx_do_push) tx_tail_q <= tx_tail_q + FIFO_AW'(1);
      if (tx_pop)     tx_head_q <= tx_head_q + FIFO_AW'(1);
      tx_cnt_q <= tx_cnt_q + (FIFO_AW+1)'(tx_do_push) - (FIFO_AW+1)'(tx_pop);
    end
  end

  // RX FIFO
  logic [7:0]         rx_mem [Depth];
  logic [FIFO_AW-1:0] rx_head_q, rx_tail_q;
  logic [FIFO_AW:0]   rx_cnt_q;
  logic               rx_empty, rx_full, rx_pop, rx_push, rx_do_push;
  assign rx_empty   = rx_cnt_q == '0;
  assign rx_full    = rx_cnt_q == Full;
  assign rx_pop     = wr_pop && !rx_empty;
  assign rx_do_push = rx_push && (!rx_full || rx_pop);

  logic [7:0] rx_sh_q;
  always_ff @(posedge clk_i) begin
    if (rx_do_push) rx_mem[rx_tail_q] <= rx_sh_q;
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      rx_head_q <= '0;
      rx_tail_q <= '0;
      rx_cnt_q  <= '0;
    end else begin
      if (rx_do_push) rx_tail_q <= rx_tail_q + FIFO_AW'(1);
      if (rx_pop)     rx_head_q <= rx_head_q + FIFO_AW'(1);
      rx_cnt_q <= rx_cnt_q + (FIFO_AW+1)'(rx_do_push) - (FIFO_AW+1)'(rx_pop);
    end
  end

  // TX FSM; the line register lags the state by one clock
  logic [7:0]  tx_sh_q;
  logic [2:0]  tx_bit_q;
  logic [15:0] tx_tick_q, tx_per_q;
  logic        tx_q, tx_line, tx_end;
  assign tx_end = tx_tick_q == tx_per_q - 16'd1;
  assign tx_o   = tx_q;

  always_comb begin
    tx_line = 1'b1;
    case (tx_state_q)
      StStart: tx_line = 1'b0;
      StData:  tx_line = tx_sh_q[0];
      default: tx_line = 1'b1;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      tx_state_q <= StIdle;
      tx_sh_q    <= '0;
      tx_bit_q   <= '0;
      tx_tick_q  <= '0;
      tx_per_q   <= DivRst[15:0];
      tx_q       <= 1'b1;
    end else begin
      tx_q <= tx_line;
      if (tx_state_q == StIdle) begin
        if (tx_pop) begin
          tx_sh_q    <= tx_mem[tx_head_q];
          tx_tick_q  <= '0;
          tx_per_q   <= div_q;
          tx_state_q <= StStart;
        end
      end else if (!tx_end) begin
        tx_tick_q <= tx_tick_q + 16'd1;
      end else begin
        // Bit boundary: the only point where a new divisor is picked up
        tx_tick_q <= '0;
        tx_per_q  <= div_q;
        case (tx_state_q)
          StStart: begin
            tx_state_q <= StData;
            tx_bit_q   <= '0;
          end
          StData: begin
            tx_sh_q  <= {1'b0, tx_sh_q[7:1]};
            tx_bit_q <= tx_bit_q + 3'd1;
            if (tx_bit_q == 3'd7) tx_state_q <= StStop;
          end
          default: tx_state_q <= StIdle;
        endcase
      end
    end
  end

  // RX synchronizer and FSM
  logic        rx_s1_q, rx_s2_q, rx_prev_q, rx_brk_q, rx_mid, rx_end, frm_set;
  logic [2:0]  rx_bit_q;
  logic [15:0] rx_tick_q, rx_per_q;
  state_e      rx_state_q;
  assign rx_mid  = rx_tick_q == {1'b0, rx_per_q[15:1]};
  assign rx_end  = rx_tick_q == rx_per_q - 16'd1;
  assign rx_push = (rx_state_q == StStop) && !rx_brk_q && rx_end && rx_s2_q;
  assign frm_set = (rx_state_q == StStop) && !rx_brk_q && rx_end && !rx_s2_q;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      rx_s1_q    <= 1'b1;
      rx_s2_q    <= 1'b1;
      rx_prev_q  <= 1'b1;
      rx_state_q <= StIdle;
      rx_brk_q   <= 1'b0;
      rx_sh_q    <= '0;
      rx_bit_q   <= '0;
      rx_tick_q  <= '0;
      rx_per_q   <= DivRst[15:0];
    end else begin
      rx_s1_q   <= rx_i;
      rx_s2_q   <= rx_s1_q;
      rx_prev_q <= rx_s2_q;
      if (rx_state_q == StIdle) begin
        if (rx_prev_q && !rx_s2_q) begin
          rx_state_q <= StStart;
          rx_tick_q  <= '0;
          rx_per_q   <= div_q;
        end
      end else if (rx_state_q == StStart) begin
        if (rx_mid) begin
          rx_tick_q  <= '0;
          rx_per_q   <= div_q;
          rx_bit_q   <= '0;
          rx_state_q <= rx_s2_q ? StIdle : StData;
        end else begin
          rx_tick_q <= rx_tick_q + 16'd1;
        end
      end else if ((rx_state_q == StStop) && rx_brk_q) begin
        // Framing error: hold off until the line returns high
        if (rx_s2_q) begin
          rx_brk_q   <= 1'b0;
          rx_state_q <= StIdle;
        end
      end else if (!rx_end) begin
        rx_tick_q <= rx_tick_q + 16'd1;
      end else begin
        rx_tick_q <= '0;
        rx_per_q  <= div_q;
        if (rx_state_q == StData) begin
          rx_sh_q  <= {rx_s2_q, rx_sh_q[7:1]};
          rx_bit_q <= rx_bit_q + 3'd1;
          if (rx_bit_q == 3'd7) rx_state_q <= StStop;
        end else if (rx_s2_q) begin
          rx_state_q <= StIdle;
        end else begin
          rx_brk_q <= 1'b1;
        end
      end
    end
  end

  // Sticky error bits, write-1-to-clear; a new event wins over a clear
  logic tx_ovf_q, rx_ovf_q, frm_err_q;
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      tx_ovf_q  <= 1'b0;
      rx_ovf_q  <= 1'b0;
      frm_err_q <= 1'b0;
    end else begin
      tx_ovf_q  <= (tx_ovf_q && !(wr_stat && din_i[7])) || (wr_data && tx_full && !tx_pop);
      frm_err_q <= (frm_err_q && !(wr_stat && din_i[6])) || frm_set;
      rx_ovf_q  <= (rx_ovf_q && !(wr_stat && din_i[5])) || (rx_push && rx_full && !rx_pop);
    end
  end

  logic [7:0] status;
  assign status = {tx_ovf_q, frm_err_q, rx_ovf_q, rx_full, !rx_empty,
                   tx_state_q != StIdle, tx_full, tx_empty};

`ifdef UART_IRQ_EN
  logic [2:0] ie_q, cause;
  logic       irq_q;
  assign cause = {tx_ovf_q || rx_ovf_q || frm_err_q, tx_empty, !rx_empty};
  assign irq_o = irq_q;
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      ie_q  <= '0;
      irq_q <= 1'b0;
    end else begin
      if (we_i && sel && (off == 8'h04)) ie_q <= din_i[2:0];
      irq_q <= |(ie_q & cause);
    end
  end
`else
  assign irq_o = 1'b0;
`endif

  always_comb begin
    dout_o = '0;
    if (sel) begin
      case (off)
        8'h00:   dout_o = {8'h00, rx_empty ? 8'h00 : rx_mem[rx_head_q]};
        8'h01:   dout_o = {8'h00, status};
        8'h03:   dout_o = div_q;
`ifdef UART_IRQ_EN
        8'h04:   dout_o = {13'h0000, ie_q};
`endif
        default: dout_o = '0;
      endcase
    end
  end
endmodule

// File: tb/tb_uart_io_16.sv
// Directed bench for uart_io_16: register-map vectors plus serial-line sequences.
module tb_uart_io_16;
  logic        clk_i = 1'b0;
  logic        reset_i, we_i, tx_o, irq_o, rx_drv, loop_en, rx_w;
  logic [15:0] addr_i, din_i, dout_o;
  int          errors = 0;
  int          checks = 0;

  always #5 clk_i = ~clk_i;
  assign rx_w = loop_en ? tx_o : rx_drv;

  uart_io_16 dut (
    .clk_i  (clk_i),
    .reset_i(reset_i),
    .addr_i (addr_i),
    .din_i  (din_i),
    .dout_o (dout_o),
    .we_i   (we_i),
    .rx_i   (rx_w),
    .tx_o   (tx_o),
    .irq_o  (irq_o)
  );

  typedef struct {
    logic        we;
    logic [15:0] addr;
    logic [15:0] din;
    logic [15:0] exp;
  } vec_t;
  vec_t vecs [14];

  task automatic check(input string nm, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic check_read(input string nm, input logic [15:0] a, input logic [15:0] exp);
    @(negedge clk_i);
    addr_i = a;
    #1 check(nm, dout_o, exp);
  endtask

  task automatic bus_write(input logic [15:0] a, input logic [15:0] d);
    @(negedge clk_i);
    addr_i = a;
    din_i  = d;
    we_i   = 1'b1;
    @(negedge clk_i);
    we_i = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk_i);
    reset_i = 1'b1;
    repeat (2) @(negedge clk_i);
    reset_i = 1'b0;
  endtask

  // Drives one frame at 8 clocks per bit
  task automatic send_frame(input logic [7:0] b, input logic stop_bit);
    @(negedge clk_i);
    rx_drv = 1'b0;
    repeat (8) @(negedge clk_i);
    for (int i = 0; i < 8; i++) begin
      rx_drv = b[i];
      repeat (8) @(negedge clk_i);
    end
    rx_drv = stop_bit;
    repeat (8) @(negedge clk_i);
    rx_drv = 1'b1;
    repeat (4) @(negedge clk_i);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [9:0] frame;
    logic       found;
    reset_i = 1'b1;
    we_i    = 1'b0;
    addr_i  = '0;
    din_i   = '0;
    rx_drv  = 1'b1;
    loop_en = 1'b0;

    do_reset();
    check("reset_tx", 16'(tx_o), 16'h0001);
    check("reset_irq", 16'(irq_o), 16'h0000);

    vecs[0]  = '{1'b0, 16'h4001, 16'h0000, 16'h0001};
    vecs[1]  = '{1'b0, 16'h4003, 16'h0000, 16'd434};
    vecs[2]  = '{1'b0, 16'h4000, 16'h0000, 16'h0000};
    vecs[3]  = '{1'b0, 16'h4002, 16'h0000, 16'h0000};
    vecs[4]  = '{1'b1, 16'h4003, 16'h0002, 16'h0000};
    vecs[5]  = '{1'b0, 16'h4003, 16'h0000, 16'h0004};
    vecs[6]  = '{1'b1, 16'h5003, 16'h1234, 16'h0000};
    vecs[7]  = '{1'b0, 16'h4003, 16'h0000, 16'h0004};
    vecs[8]  = '{1'b0, 16'h5003, 16'h0000, 16'h0000};
    vecs[9]  = '{1'b1, 16'h4003, 16'h0008, 16'h0000};
    vecs[10] = '{1'b0, 16'h4003, 16'h0000, 16'h0008};
    vecs[11] = '{1'b1, 16'h4002, 16'h0000, 16'h0000};
    vecs[12] = '{1'b1, 16'h4001, 16'h00E0, 16'h0000};
    vecs[13] = '{1'b0, 16'h4001, 16'h0000, 16'h0001};
    for (int v = 0; v < 14; v++) begin
      if (vecs[v].we) bus_write(vecs[v].addr, vecs[v].din);
      else check_read($sformatf("vec%0d", v), vecs[v].addr, vecs[v].exp);
    end

    // TX single byte 0xA5 at DIV=8: start, 1,0,1,0,0,1,0,1, stop
    frame = 10'b1101001010;
    @(negedge clk_i);
    addr_i = 16'h4000;
    din_i  = 16'h00A5;
    we_i   = 1'b1;
    @(posedge clk_i);
    #1 we_i = 1'b0;
    @(posedge clk_i);
    #1 check("tx_e1_high", 16'(tx_o), 16'h0001);
    @(posedge clk_i);
    #1 check("tx_e2_fall", 16'(tx_o), 16'h0000);
    for (int k = 0; k < 10; k++) begin
      repeat (4) @(posedge clk_i);
      #1 check($sformatf("tx_bit%0d", k), 16'(tx_o), 16'(frame[k]));
      repeat (4) @(posedge clk_i);
    end
    #1 addr_i = 16'h4001;
    #1 check("tx_done_status", dout_o, 16'h0001);

    // TX overflow: 17 writes fill the FIFO, the 18th meets full with no pop
    for (int i = 0; i < 18; i++) begin
      @(negedge clk_i);
      if (i == 17) begin
        we_i   = 1'b0;
        addr_i = 16'h4001;
        #1 check("tx_full_no_ovf", dout_o, 16'h0006);
      end
      addr_i = 16'h4000;
      din_i  = 16'(i);
      we_i   = 1'b1;
    end
    @(negedge clk_i);
    we_i   = 1'b0;
    addr_i = 16'h4001;
    #1 check("tx_ovf_set", dout_o, 16'h0086);
    din_i = 16'h0080;
    we_i  = 1'b1;
    @(negedge clk_i);
    we_i = 1'b0;
    #1 check("tx_ovf_clear", dout_o, 16'h0006);
    // First frame ends after E0+81; next falls one idle cycle later at E0+83
    repeat (64) @(posedge clk_i);
    #1 check("tx_gap_high", 16'(tx_o), 16'h0001);
    @(posedge clk_i);
    #1 check("tx_second_fall", 16'(tx_o), 16'h0000);

    // RX loopback
    do_reset();
    check_read("reset_clears_tx", 16'h4001, 16'h0001);
    bus_write(16'h4003, 16'h0008);
    loop_en = 1'b1;
    bus_write(16'h4000, 16'h003C);
    repeat (110) @(negedge clk_i);
    check_read("loop_status", 16'h4001, 16'h0009);
    check_read("loop_data", 16'h4000, 16'h003C);
    check("loop_irq_off", 16'(irq_o), 16'h0000);
    bus_write(16'h4002, 16'h0000);
    check_read("loop_popped", 16'h4001, 16'h0001);
    loop_en = 1'b0;

    // RX framing error, then glitch
    send_frame(8'h55, 1'b0);
    check_read("frm_err_set", 16'h4001, 16'h0041);
    check_read("frm_no_push", 16'h4000, 16'h0000);
    bus_write(16'h4001, 16'h0040);
    check_read("frm_err_clear", 16'h4001, 16'h0001);
    @(negedge clk_i);
    rx_drv = 1'b0;
    repeat (2) @(negedge clk_i);
    rx_drv = 1'b1;
    repeat (20) @(negedge clk_i);
    check_read("glitch_status", 16'h4001, 16'h0001);

    // RX overflow: 17 frames, no pops
    for (int i = 0; i < 17; i++) send_frame(8'(8'h10 + i), 1'b1);
    check_read("rx_ovf_status", 16'h4001, 16'h0039);
    for (int i = 0; i < 16; i++) begin
      check_read($sformatf("rx_order%0d", i), 16'h4000, 16'(8'h10 + i));
      bus_write(16'h4002, 16'h0000);
    end
    check_read("rx_drained", 16'h4001, 16'h0021);

    // Reset mid-frame: second 0x00 frame is in DATA with tx low
    do_reset();
    bus_write(16'h4003, 16'h0008);
    loop_en = 1'b1;
    bus_write(16'h4000, 16'h0000);
    bus_write(16'h4000, 16'h0000);
    repeat (100) @(negedge clk_i);
    check("midframe_tx_low", 16'(tx_o), 16'h0000);
    check_read("midframe_status", 16'h4001, 16'h000D);
    @(negedge clk_i);
    reset_i = 1'b1;
    @(posedge clk_i);
    #1 check("midframe_reset_tx", 16'(tx_o), 16'h0001);
    @(negedge clk_i);
    reset_i = 1'b0;
    check_read("midframe_fifos", 16'h4001, 16'h0001);
    check_read("midframe_rx_empty", 16'h4000, 16'h0000);
    check_read("midframe_div", 16'h4003, 16'd434);

`ifdef UART_IRQ_EN
    bus_write(16'h4003, 16'h0008);
    bus_write(16'h4004, 16'h0001);
    check_read("ie_readback", 16'h4004, 16'h0001);
    bus_write(16'h4000, 16'h005A);
    addr_i = 16'h4001;
    found  = 1'b0;
    for (int c = 0; c < 200 && !found; c++) begin
      @(posedge clk_i);
      #1;
      if (dout_o[3]) begin
        found = 1'b1;
        check("irq_lag", 16'(irq_o), 16'h0000);
        @(posedge clk_i);
        #1 check("irq_rise", 16'(irq_o), 16'h0001);
      end
    end
    check("irq_rx_avail_seen", 16'(found), 16'h0001);
    @(negedge clk_i);
    addr_i = 16'h4002;
    we_i   = 1'b1;
    @(posedge clk_i);
    #1 we_i = 1'b0;
    check("irq_hold", 16'(irq_o), 16'h0001);
    @(posedge clk_i);
    #1 check("irq_fall", 16'(irq_o), 16'h0000);
`else
    bus_write(16'h4004, 16'h0007);
    check_read("ie_absent", 16'h4004, 16'h0000);
    check("irq_tied_low", 16'(irq_o), 16'h0000);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
